// File: rtl/fft_unload.sv
`default_nettype none
// ============================================================================
// Module : fft_unload
// Reads one FFT result bank in natural or bit-reversed order and streams it
// out through a 2-entry FIFO with a valid/ready handshake.
// Rev    : 1.0
// ============================================================================
module fft_unload #(
    parameter int  DATA_WIDTH = 32,
    parameter int  N_POINTS   = 8,
    parameter int  BITREV_OUT = 0,
    localparam int ADDR_WIDTH = $clog2(N_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_done,
    input  logic                  read_mem_sel,
    output logic                  mem_1_rd_en,
    output logic                  mem_2_rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_1_rdata,
    input  logic [DATA_WIDTH-1:0] mem_2_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  busy,
    output logic                  unload_done,
    output logic                  drop
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(N_POINTS - 1);

    state_t                  state_q;
    logic                    bank_q;
    logic [ADDR_WIDTH-1:0]   k_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   infl_idx_q;
    logic [1:0]              count_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [ADDR_WIDTH-1:0]   fifo_idx_q  [2];
    logic                    fifo_last_q [2];
    logic                    unload_done_q;
    logic                    drop_q;

    logic                    w_pop;
    logic                    w_issue;
    logic [2:0]              count_d;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Occupancy after this edge; a new read is only safe if its data will fit.
    assign w_pop   = m_valid & m_ready;
    assign count_d = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue = (state_q == S_READ) && !rst && (count_d < 3'd2);
    assign w_rdata = bank_q ? mem_2_rdata : mem_1_rdata;

    generate
        if (BITREV_OUT != 0) begin : g_bitrev
            for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_bit
                assign rd_addr[i] = k_q[ADDR_WIDTH-1-i];
            end
        end else begin : g_natural
            assign rd_addr = k_q;
        end
    endgenerate

    assign mem_1_rd_en = w_issue & ~bank_q;
    assign mem_2_rd_en = w_issue & bank_q;
    assign m_valid     = (count_q != 2'd0);
    assign m_data      = fifo_data_q[rd_ptr_q];
    assign m_index     = fifo_idx_q[rd_ptr_q];
    assign m_last      = fifo_last_q[rd_ptr_q];
    assign busy        = (state_q != S_IDLE);
    assign unload_done = unload_done_q;
    assign drop        = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bank_q        <= 1'b0;
            k_q           <= '0;
            inflight_q    <= 1'b0;
            infl_idx_q    <= '0;
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            unload_done_q <= 1'b0;
            drop_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            unload_done_q <= 1'b0;
            drop_q        <= fft_done & busy;
            inflight_q    <= w_issue;
            count_q       <= count_d[1:0];

            if (w_issue) begin
                infl_idx_q <= k_q;
                k_q        <= k_q + ADDR_WIDTH'(1);
            end

            // Memory data lands one cycle after its read was issued.
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= w_rdata;
                fifo_idx_q[wr_ptr_q]  <= infl_idx_q;
                fifo_last_q[wr_ptr_q] <= (infl_idx_q == c_last_idx);
                wr_ptr_q              <= ~wr_ptr_q;
            end

            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (fft_done) begin
                        bank_q  <= read_mem_sel;
                        k_q     <= '0;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue && (k_q == c_last_idx)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && m_last) begin
                        state_q       <= S_IDLE;
                        unload_done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_unload.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_unload
// Bench for fft_unload: natural-order and bit-reversed instances run side by
// side against a bin-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_fft_unload;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_done = 1'b0;
    logic        read_mem_sel = 1'b0;
    logic        m_ready = 1'b1;
    bit          rnd_ready = 1'b0;

    logic        en1 [2];
    logic        en2 [2];
    logic [2:0]  addr [2];
    logic [31:0] r1 [2];
    logic [31:0] r2 [2];
    logic [31:0] md [2];
    logic        mv [2];
    logic        ml [2];
    logic [2:0]  mi [2];
    logic        bz [2];
    logic        ud [2];
    logic        dp [2];

    logic [31:0] mem1 [8];
    logic [31:0] mem2 [8];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    // Observation records filled by the monitor
    int          xc [2][64];
    logic [31:0] xd [2][64];
    int          xi [2][64];
    bit          xl [2][64];
    int          xn [2];
    int          rs [2][64];
    int          rn [2];
    int          dc [2][8];
    int          dn [2];
    int          drc [2][8];
    int          drn [2];
    int          stab_err [2];
    int          both_err [2];
    bit          stall_prev [2];
    logic [31:0] pd [2];
    logic [2:0]  pi [2];
    logic        pl [2];

    fft_unload #(.DATA_WIDTH(32), .N_POINTS(8), .BITREV_OUT(0)) u_nat (
        .clk(clk), .rst(rst), .fft_done(fft_done), .read_mem_sel(read_mem_sel),
        .mem_1_rd_en(en1[0]), .mem_2_rd_en(en2[0]), .rd_addr(addr[0]),
        .mem_1_rdata(r1[0]), .mem_2_rdata(r2[0]),
        .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready), .m_last(ml[0]), .m_index(mi[0]),
        .busy(bz[0]), .unload_done(ud[0]), .drop(dp[0])
    );

    fft_unload #(.DATA_WIDTH(32), .N_POINTS(8), .BITREV_OUT(1)) u_rev (
        .clk(clk), .rst(rst), .fft_done(fft_done), .read_mem_sel(read_mem_sel),
        .mem_1_rd_en(en1[1]), .mem_2_rd_en(en2[1]), .rd_addr(addr[1]),
        .mem_1_rdata(r1[1]), .mem_2_rdata(r2[1]),
        .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready), .m_last(ml[1]), .m_index(mi[1]),
        .busy(bz[1]), .unload_done(ud[1]), .drop(dp[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories; garbage when not enabled
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            r1[u] <= en1[u] ? mem1[addr[u]] : $urandom();
            r2[u] <= en2[u] ? mem2[addr[u]] : $urandom();
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mv[u] && m_ready) begin
                if (xn[u] < 64) begin
                    xc[u][xn[u]] = cyc;
                    xd[u][xn[u]] = md[u];
                    xi[u][xn[u]] = int'(mi[u]);
                    xl[u][xn[u]] = ml[u];
                end
                xn[u]++;
            end
            if (en1[u] && en2[u]) both_err[u]++;
            if (en1[u] || en2[u]) begin
                if (rn[u] < 64) rs[u][rn[u]] = (en2[u] ? 16 : 0) + int'(addr[u]);
                rn[u]++;
            end
            if (ud[u]) begin
                if (dn[u] < 8) dc[u][dn[u]] = cyc;
                dn[u]++;
            end
            if (dp[u]) begin
                if (drn[u] < 8) drc[u][drn[u]] = cyc;
                drn[u]++;
            end
            if (stall_prev[u] && !(mv[u] && md[u] == pd[u] && mi[u] == pi[u] && ml[u] == pl[u]))
                stab_err[u]++;
            stall_prev[u] = mv[u] && !m_ready && !rst;
            pd[u] = md[u];
            pi[u] = mi[u];
            pl[u] = ml[u];
        end
    end

    // Reference model: bin b of bank is stored at b (natural) or bitrev(b)
    function automatic int brev(int b);
        return ((b & 1) << 2) | (b & 2) | ((b >> 2) & 1);
    endfunction

    function automatic logic [31:0] exp_data(int u, bit bank, int bin);
        int a = (u == 1) ? brev(bin) : bin;
        return bank ? mem2[a] : mem1[a];
    endfunction

    function automatic int exp_rd(int u, bit bank, int bin);
        return (bank ? 16 : 0) + ((u == 1) ? brev(bin) : bin);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        for (int u = 0; u < 2; u++) begin
            xn[u] = 0; rn[u] = 0; dn[u] = 0; drn[u] = 0;
            stab_err[u] = 0; both_err[u] = 0;
        end
    endtask

    task automatic load_spec_mem();
        for (int i = 0; i < 8; i++) begin
            mem1[i] = 32'h100 + i;
            mem2[i] = 32'h200 + i;
        end
    endtask

    task automatic load_rand_mem();
        for (int i = 0; i < 8; i++) begin
            mem1[i] = $urandom();
            mem2[i] = $urandom();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if ({mv[u], ml[u], bz[u], ud[u], dp[u]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_flags u%0d: got valid/last/busy/done/drop=%b want 00000", u, {mv[u], ml[u], bz[u], ud[u], dp[u]});
            end
            n_cmp++;
            if ({en1[u], en2[u]} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_rden u%0d: got %b want 00", u, {en1[u], en2[u]});
            end
            n_cmp++;
            if (md[u] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data u%0d: got %h want 0", u, md[u]);
            end
            n_cmp++;
            if (mi[u] !== 3'd0 || addr[u] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_index_addr u%0d: got index=%0d addr=%0d want 0/0", u, mi[u], addr[u]);
            end
        end
    endtask

    task automatic test_basic(input bit sel);
        int t;
        load_spec_mem();
        rnd_ready = 1'b0;
        tick();
        clear_obs();
        t = cyc;
        fft_done = 1'b1;
        read_mem_sel = sel;
        tick();
        fft_done = 1'b0;
        read_mem_sel = ~sel;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (bz[u] !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_busy u%0d: got %b want 1", u, bz[u]);
            end
        end
        for (int k = 0; k < 60 && (dn[0] < 1 || dn[1] < 1); k++) tick();
        repeat (3) tick();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (xn[u] !== 8) begin
                n_fail++;
                $display("FAIL basic_count u%0d sel%0d: got %0d transfers want 8", u, sel, xn[u]);
            end
            for (int i = 0; i < 8 && i < xn[u]; i++) begin
                n_cmp++;
                if (xc[u][i] !== t + 3 + i || xd[u][i] !== exp_data(u, sel, i) || xi[u][i] !== i || xl[u][i] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL basic_xfer u%0d sel%0d i%0d: got cyc=%0d data=%h idx=%0d last=%0b want cyc=%0d data=%h idx=%0d last=%0b",
                             u, sel, i, xc[u][i] - t, xd[u][i], xi[u][i], xl[u][i], 3 + i, exp_data(u, sel, i), i, (i == 7));
                end
            end
            n_cmp++;
            if (rn[u] !== 8) begin
                n_fail++;
                $display("FAIL basic_reads u%0d: got %0d reads want 8", u, rn[u]);
            end
            for (int i = 0; i < 8 && i < rn[u]; i++) begin
                n_cmp++;
                if (rs[u][i] !== exp_rd(u, sel, i)) begin
                    n_fail++;
                    $display("FAIL basic_rdaddr u%0d i%0d: got bank*16+addr=%0d want %0d", u, i, rs[u][i], exp_rd(u, sel, i));
                end
            end
            n_cmp++;
            if (dn[u] !== 1 || dc[u][0] !== t + 11) begin
                n_fail++;
                $display("FAIL basic_done u%0d: got %0d pulses first at +%0d want 1 at +11", u, dn[u], dc[u][0] - t);
            end
            n_cmp++;
            if (drn[u] !== 0 || both_err[u] !== 0 || bz[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_misc u%0d: got drops=%0d both_rden=%0d busy=%b want 0/0/0", u, drn[u], both_err[u], bz[u]);
            end
        end
    endtask

    task automatic test_random_ready();
        bit sel;
        for (int it = 0; it < 4; it++) begin
            load_rand_mem();
            sel = 1'($urandom_range(0, 1));
            tick();
            clear_obs();
            rnd_ready = 1'b1;
            fft_done = 1'b1;
            read_mem_sel = sel;
            tick();
            fft_done = 1'b0;
            n_cmp++;
            for (int k = 0; k < 300 && (dn[0] < 1 || dn[1] < 1); k++) tick();
            if (dn[0] < 1 || dn[1] < 1) begin
                n_fail++;
                $display("FAIL rand_timeout it%0d: got done=%0d/%0d want 1/1", it, dn[0], dn[1]);
            end
            rnd_ready = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                n_cmp++;
                if (xn[u] !== 8 || rn[u] !== 8 || dn[u] !== 1) begin
                    n_fail++;
                    $display("FAIL rand_counts u%0d it%0d: got xfers=%0d reads=%0d done=%0d want 8/8/1", u, it, xn[u], rn[u], dn[u]);
                end
                for (int i = 0; i < 8 && i < xn[u]; i++) begin
                    n_cmp++;
                    if (xd[u][i] !== exp_data(u, sel, i) || xi[u][i] !== i || xl[u][i] !== (i == 7)) begin
                        n_fail++;
                        $display("FAIL rand_xfer u%0d it%0d i%0d: got data=%h idx=%0d last=%0b want data=%h idx=%0d last=%0b",
                                 u, it, i, xd[u][i], xi[u][i], xl[u][i], exp_data(u, sel, i), i, (i == 7));
                    end
                end
                n_cmp++;
                if (stab_err[u] !== 0 || both_err[u] !== 0) begin
                    n_fail++;
                    $display("FAIL rand_stall u%0d it%0d: got unstable=%0d both_rden=%0d want 0/0", u, it, stab_err[u], both_err[u]);
                end
            end
        end
    endtask

    task automatic test_drop();
        int t;
        bit sel;
        load_rand_mem();
        sel = 1'($urandom_range(0, 1));
        tick();
        clear_obs();
        t = cyc;
        fft_done = 1'b1;
        read_mem_sel = sel;
        tick();
        fft_done = 1'b0;
        read_mem_sel = ~sel;
        while (cyc < t + 5) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        for (int k = 0; k < 60 && (dn[0] < 1 || dn[1] < 1); k++) tick();
        repeat (8) tick();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (drn[u] !== 1 || drc[u][0] !== t + 6) begin
                n_fail++;
                $display("FAIL drop_pulse u%0d: got %0d pulses first at +%0d want 1 at +6", u, drn[u], drc[u][0] - t);
            end
            n_cmp++;
            if (xn[u] !== 8 || rn[u] !== 8 || dn[u] !== 1 || dc[u][0] !== t + 11) begin
                n_fail++;
                $display("FAIL drop_single u%0d: got xfers=%0d reads=%0d done=%0d at +%0d want 8/8/1 at +11", u, xn[u], rn[u], dn[u], dc[u][0] - t);
            end
            for (int i = 0; i < 8 && i < xn[u]; i++) begin
                n_cmp++;
                if (xc[u][i] !== t + 3 + i || xd[u][i] !== exp_data(u, sel, i) || xi[u][i] !== i) begin
                    n_fail++;
                    $display("FAIL drop_xfer u%0d i%0d: got cyc=+%0d data=%h idx=%0d want cyc=+%0d data=%h idx=%0d",
                             u, i, xc[u][i] - t, xd[u][i], xi[u][i], 3 + i, exp_data(u, sel, i), i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int t2;
        bit sel;
        load_rand_mem();
        sel = 1'($urandom_range(0, 1));
        tick();
        clear_obs();
        t = cyc;
        fft_done = 1'b1;
        read_mem_sel = sel;
        tick();
        fft_done = 1'b0;
        while (cyc < t + 6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (mv[u] !== 1'b0 || bz[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle u%0d: got valid=%b busy=%b want 0/0", u, mv[u], bz[u]);
            end
        end
        while (cyc < t + 10) tick();
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (xn[u] !== 4 || dn[u] !== 0) begin
                n_fail++;
                $display("FAIL rstmid_abandon u%0d: got xfers=%0d done=%0d want 4/0", u, xn[u], dn[u]);
            end
        end
        clear_obs();
        sel = 1'($urandom_range(0, 1));
        t2 = cyc;
        fft_done = 1'b1;
        read_mem_sel = sel;
        tick();
        fft_done = 1'b0;
        for (int k = 0; k < 60 && (dn[0] < 1 || dn[1] < 1); k++) tick();
        repeat (3) tick();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (xn[u] !== 8 || dn[u] !== 1 || dc[u][0] !== t2 + 11) begin
                n_fail++;
                $display("FAIL rstmid_restart u%0d: got xfers=%0d done=%0d at +%0d want 8/1 at +11", u, xn[u], dn[u], dc[u][0] - t2);
            end
            for (int i = 0; i < 8 && i < xn[u]; i++) begin
                n_cmp++;
                if (xc[u][i] !== t2 + 3 + i || xd[u][i] !== exp_data(u, sel, i) || xi[u][i] !== i || xl[u][i] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL rstmid_xfer u%0d i%0d: got cyc=+%0d data=%h idx=%0d last=%0b want cyc=+%0d data=%h idx=%0d last=%0b",
                             u, i, xc[u][i] - t2, xd[u][i], xi[u][i], xl[u][i], 3 + i, exp_data(u, sel, i), i, (i == 7));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        bit sel;
        bit bank;
        int bin;
        int ecyc;
        load_rand_mem();
        sel = 1'($urandom_range(0, 1));
        tick();
        clear_obs();
        t = cyc;
        fft_done = 1'b1;
        read_mem_sel = sel;
        tick();
        fft_done = 1'b0;
        read_mem_sel = ~sel;
        while (cyc < t + 11) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        for (int k = 0; k < 60 && (dn[0] < 2 || dn[1] < 2); k++) tick();
        repeat (3) tick();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (dn[u] !== 2 || dc[u][0] !== t + 11 || dc[u][1] !== t + 22 || drn[u] !== 0) begin
                n_fail++;
                $display("FAIL b2b_done u%0d: got done=%0d at +%0d,+%0d drops=%0d want 2 at +11,+22 drops=0",
                         u, dn[u], dc[u][0] - t, dc[u][1] - t, drn[u]);
            end
            n_cmp++;
            if (xn[u] !== 16 || rn[u] !== 16) begin
                n_fail++;
                $display("FAIL b2b_count u%0d: got xfers=%0d reads=%0d want 16/16", u, xn[u], rn[u]);
            end
            for (int i = 0; i < 16 && i < xn[u]; i++) begin
                bank = (i < 8) ? sel : ~sel;
                bin  = i % 8;
                ecyc = (i < 8) ? t + 3 + i : t + 14 + bin;
                n_cmp++;
                if (xc[u][i] !== ecyc || xd[u][i] !== exp_data(u, bank, bin) || xi[u][i] !== bin) begin
                    n_fail++;
                    $display("FAIL b2b_xfer u%0d i%0d: got cyc=+%0d data=%h idx=%0d want cyc=+%0d data=%h idx=%0d",
                             u, i, xc[u][i] - t, xd[u][i], xi[u][i], ecyc - t, exp_data(u, bank, bin), bin);
                end
            end
        end
    endtask

    initial begin
        clear_obs();
        for (int u = 0; u < 2; u++) stall_prev[u] = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_random_ready();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_unload.md
FFT_UNLOAD -- requirements
Module: fft_unload

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one memory word (packed complex sample).
REQ-002 SHALL have parameter N_POINTS, default 8: FFT length; ADDR_WIDTH = log2(N_POINTS) is derived, not a port.
REQ-003 SHALL have parameter BITREV_OUT, default 0: when 1, samples are read in bit-reversed address order.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk input 1, clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports: fft_done input 1, one-cycle pulse meaning results are complete; read_mem_sel input 1, bank holding results (0 = mem_1, 1 = mem_2).
REQ-006 SHALL have ports: mem_1_rd_en output 1; mem_2_rd_en output 1; rd_addr output ADDR_WIDTH, shared read address.
REQ-007 SHALL have ports: mem_1_rdata input DATA_WIDTH; mem_2_rdata input DATA_WIDTH; both valid exactly 1 cycle after the matching rd_en.
REQ-008 SHALL have ports: m_data output DATA_WIDTH; m_valid output 1; m_ready input 1; m_last output 1; m_index output ADDR_WIDTH, natural-order bin number of m_data.
REQ-009 SHALL have ports: busy output 1; unload_done output 1, one-cycle pulse; drop output 1, one-cycle pulse.

Function
REQ-010 SHALL implement states IDLE, READ, DRAIN.
REQ-011 IDLE: on fft_done=1, latch read_mem_sel into bank register, clear read counter k, go to READ next cycle; busy=1 from that next cycle.
REQ-012 READ: issue a read (rd_en of latched bank =1, other bank rd_en=0) when count + inflight - pop < 2, where count = output buffer occupancy (0..2), inflight = read issued last cycle, pop = m_valid & m_ready.
REQ-013 rd_addr SHALL be k when BITREV_OUT=0, bit-reverse(k) when BITREV_OUT=1; k increments per issued read; after read k = N_POINTS-1, go to DRAIN.
REQ-014 Returned data (bank selected by latched register) SHALL be written into a 2-entry FIFO the cycle after issue, together with its index k and last flag (k = N_POINTS-1).
REQ-015 m_valid = FIFO non-empty; m_data/m_index/m_last come from FIFO head; SHALL hold stable while m_valid=1 and m_ready=0.
REQ-016 A transfer occurs on m_valid & m_ready; FIFO pops that cycle; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-017 With m_ready held 1, throughput SHALL be one sample per cycle; FIFO SHALL never overflow under any m_ready pattern.
REQ-018 Latency: fft_done at cycle t -> first rd_en at t+1 -> first m_valid at t+3; with m_ready=1 the m_last transfer occurs at t+3+N_POINTS-1.
REQ-019 DRAIN: no reads issued; after the m_last transfer, unload_done=1 for exactly the next cycle, state IDLE, busy=0 that same cycle.
REQ-020 fft_done while busy=1 SHALL be ignored (no restart, bank register unchanged) and SHALL pulse drop=1 the following cycle.
REQ-021 fft_done in the same cycle unload_done is high SHALL start a new unload normally (state is IDLE).
REQ-022 rd_en outputs SHALL be 0 in IDLE and DRAIN; both rd_en SHALL never be 1 together.

Reset
REQ-023 rst=1 SHALL force next cycle: state IDLE, k=0, FIFO empty, inflight=0, bank register 0.
REQ-024 Reset values: m_valid=0, m_last=0, m_index=0, m_data=0, mem_1_rd_en=0, mem_2_rd_en=0, rd_addr=0, busy=0, unload_done=0, drop=0.
REQ-025 rst asserted mid-unload SHALL abandon the unload with no further transfers; read data returning the cycle after reset SHALL be discarded.

Verification
REQ-026 Bank 0 holds 0x100+i at address i, BITREV_OUT=0, m_ready=1, fft_done at t -> m_valid at t+3, 8 transfers 0x100..0x107 on consecutive cycles, m_last on 0x107, unload_done at t+11.
REQ-027 BITREV_OUT=1, read_mem_sel=1, mem_2 holds 0x200+i -> rd_addr sequence 0,4,2,6,1,5,3,7; m_index 0..7; mem_1_rd_en never 1.
REQ-028 m_ready pattern 1,0,0,1,0,1,... random -> all 8 samples delivered once, in order, data stable during stalls, FIFO occupancy never exceeds 2.
REQ-029 Second fft_done at t+5 during unload -> drop=1 at t+6, current unload completes unchanged, no second unload.
REQ-030 rst at t+6 mid-unload -> m_valid=0, busy=0 from t+7; new fft_done at t+10 -> clean full unload starting with index 0.
REQ-031 fft_done coincident with unload_done -> back-to-back unload, first m_valid 3 cycles later, no drop pulse.
